// File: rtl/cv32e40p_tmr_breakage_monitor.sv
// Per-replica up/down fault counters behind a TMR voter; flags broken replicas and a sticky fatal condition.
// All outputs are registered and appear the cycle after the causing input; there is no backpressure and a new sample is accepted every cycle.
module cv32e40p_tmr_breakage_monitor #(
  parameter int DECREMENT          = 1,
  parameter int INCREMENT          = 1,
  parameter int BREAKING_THRESHOLD = 3,
  parameter int COUNT_BIT          = 8,
  parameter int INC_DEC_BIT        = 2
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   valid_i,
  input  logic [2:0]             err_i,
  input  logic                   clear_i,
  output logic [2:0]             broken_o,
  output logic [2:0]             suspect_o,
  output logic                   fatal_o,
  output logic                   broken_event_o,
  output logic [3*COUNT_BIT-1:0] count_o
);

  localparam int CW = COUNT_BIT + 1;
  localparam logic [INC_DEC_BIT-1:0] INC_C = INC_DEC_BIT'(INCREMENT);
  localparam logic [INC_DEC_BIT-1:0] DEC_C = INC_DEC_BIT'(DECREMENT);
  localparam logic [CW-1:0] INC_X = CW'(INC_C);
  localparam logic [CW-1:0] DEC_X = CW'(DEC_C);
  localparam logic [CW-1:0] THR_X = CW'(BREAKING_THRESHOLD);
  localparam logic [CW-1:0] MAX_X = CW'((2 ** COUNT_BIT) - 1);

  typedef enum logic [1:0] {ST_OK, ST_SUSPECT, ST_BROKEN} state_t;

  state_t               state_q [3];
  state_t               state_d [3];
  logic [COUNT_BIT-1:0] count_q [3];
  logic [COUNT_BIT-1:0] count_d [3];
  logic                 fatal_q, fatal_d;
  logic                 event_q, event_d;
  logic [2:0]           masked_err;
  logic [1:0]           n_err, n_brk;
  logic [CW-1:0]        sum;

  always_comb begin
    for (int i = 0; i < 3; i++) begin
      broken_o[i]  = (state_q[i] == ST_BROKEN);
      suspect_o[i] = (state_q[i] == ST_SUSPECT);
      count_o[i*COUNT_BIT +: COUNT_BIT] = count_q[i];
    end
    fatal_o        = fatal_q;
    broken_event_o = event_q;
  end

  assign masked_err = err_i & ~broken_o;

  always_comb begin
    n_err   = '0;
    n_brk   = '0;
    sum     = '0;
    event_d = 1'b0;
    for (int i = 0; i < 3; i++) begin
      state_d[i] = state_q[i];
      count_d[i] = count_q[i];
      n_err      = n_err + {1'b0, masked_err[i]};
      if (valid_i && state_q[i] != ST_BROKEN) begin
        // Arithmetic one bit wider so saturation and flooring never wrap.
        if (masked_err[i]) begin
          sum = {1'b0, count_q[i]} + INC_X;
          if (sum > MAX_X) sum = MAX_X;
        end else begin
          sum = ({1'b0, count_q[i]} >= DEC_X) ? ({1'b0, count_q[i]} - DEC_X) : '0;
        end
        count_d[i] = sum[COUNT_BIT-1:0];
        if (sum >= THR_X) begin
          state_d[i] = ST_BROKEN;
          event_d    = 1'b1;
        end else if (sum == '0) begin
          state_d[i] = ST_OK;
        end else begin
          state_d[i] = ST_SUSPECT;
        end
      end
      if (state_d[i] == ST_BROKEN) n_brk = n_brk + 2'd1;
    end
    fatal_d = fatal_q | (valid_i && n_err >= 2'd2) | (n_brk >= 2'd2);
    if (clear_i) begin
      for (int i = 0; i < 3; i++) begin
        state_d[i] = ST_OK;
        count_d[i] = '0;
      end
      fatal_d = 1'b0;
      event_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 3; i++) begin
        state_q[i] <= ST_OK;
        count_q[i] <= '0;
      end
      fatal_q <= 1'b0;
      event_q <= 1'b0;
    end else begin
      for (int i = 0; i < 3; i++) begin
        state_q[i] <= state_d[i];
        count_q[i] <= count_d[i];
      end
      fatal_q <= fatal_d;
      event_q <= event_d;
    end
  end

endmodule

// File: tb/tb_cv32e40p_tmr_breakage_monitor.sv
// Bench for the breakage monitor: directed scenarios then random traffic, both checked against a counter model.
module tb_cv32e40p_tmr_breakage_monitor;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       valid_i;
  logic [2:0] err_i;
  logic       clear_i;

  logic [2:0]  brk_a, sus_a, brk_b, sus_b;
  logic        fat_a, ev_a, fat_b, ev_b;
  logic [23:0] cnt_a;
  logic [5:0]  cnt_b;

  int n_tests = 0;
  int n_fail  = 0;

  // Model state: index 0 = default instance, 1 = narrow saturating instance.
  int mcnt [2][3];
  bit mbrk [2][3];
  bit mfat [2];
  bit mev  [2];
  int p_inc [2] = '{1, 3};
  int p_dec [2] = '{1, 1};
  int p_thr [2] = '{3, 3};
  int p_max [2] = '{255, 3};
  int p_cb  [2] = '{8, 2};

  always #5 clk = ~clk;

  cv32e40p_tmr_breakage_monitor dut_a (
    .clk(clk), .rst_n(rst_n), .valid_i(valid_i), .err_i(err_i), .clear_i(clear_i),
    .broken_o(brk_a), .suspect_o(sus_a), .fatal_o(fat_a), .broken_event_o(ev_a), .count_o(cnt_a)
  );

  cv32e40p_tmr_breakage_monitor #(
    .DECREMENT(1), .INCREMENT(3), .BREAKING_THRESHOLD(3), .COUNT_BIT(2), .INC_DEC_BIT(2)
  ) dut_b (
    .clk(clk), .rst_n(rst_n), .valid_i(valid_i), .err_i(err_i), .clear_i(clear_i),
    .broken_o(brk_b), .suspect_o(sus_b), .fatal_o(fat_b), .broken_event_o(ev_b), .count_o(cnt_b)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int m = 0; m < 2; m++) begin
      for (int i = 0; i < 3; i++) begin
        mcnt[m][i] = 0;
        mbrk[m][i] = 0;
      end
      mfat[m] = 0;
      mev[m]  = 0;
    end
  endtask

  task automatic model_step(input bit v, input bit [2:0] e, input bit c);
    for (int m = 0; m < 2; m++) begin
      mev[m] = 0;
      if (c) begin
        for (int i = 0; i < 3; i++) begin
          mcnt[m][i] = 0;
          mbrk[m][i] = 0;
        end
        mfat[m] = 0;
      end else if (v) begin
        int nerr = 0;
        int nb = 0;
        for (int i = 0; i < 3; i++) begin
          if (!mbrk[m][i]) begin
            if (e[i]) begin
              nerr++;
              mcnt[m][i] = (mcnt[m][i] + p_inc[m] > p_max[m]) ? p_max[m] : mcnt[m][i] + p_inc[m];
            end else begin
              mcnt[m][i] = (mcnt[m][i] - p_dec[m] < 0) ? 0 : mcnt[m][i] - p_dec[m];
            end
            if (mcnt[m][i] >= p_thr[m]) begin
              mbrk[m][i] = 1;
              mev[m] = 1;
            end
          end
        end
        for (int i = 0; i < 3; i++) nb += int'(mbrk[m][i]);
        if (nerr >= 2 || nb >= 2) mfat[m] = 1;
      end
    end
  endtask

  task automatic check_all();
    for (int m = 0; m < 2; m++) begin
      logic [2:0]  eb, es;
      logic [31:0] ec;
      ec = 0;
      for (int i = 0; i < 3; i++) begin
        eb[i] = mbrk[m][i];
        es[i] = (mcnt[m][i] != 0) && !mbrk[m][i];
        ec = ec | (32'(mcnt[m][i]) << (i * p_cb[m]));
      end
      if (m == 0) begin
        chk("a.broken", 32'(brk_a), 32'(eb));
        chk("a.suspect", 32'(sus_a), 32'(es));
        chk("a.fatal", 32'(fat_a), 32'(mfat[0]));
        chk("a.event", 32'(ev_a), 32'(mev[0]));
        chk("a.count", 32'(cnt_a), ec);
      end else begin
        chk("b.broken", 32'(brk_b), 32'(eb));
        chk("b.suspect", 32'(sus_b), 32'(es));
        chk("b.fatal", 32'(fat_b), 32'(mfat[1]));
        chk("b.event", 32'(ev_b), 32'(mev[1]));
        chk("b.count", 32'(cnt_b), ec);
      end
    end
  endtask

  task automatic cyc(input bit v, input bit [2:0] e, input bit c);
    valid_i = v;
    err_i   = e;
    clear_i = c;
    @(posedge clk);
    model_step(v, e, c);
    #1;
    check_all();
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, ".broken"}, 32'({brk_a, brk_b}), 32'd0);
    chk({tag, ".suspect"}, 32'({sus_a, sus_b}), 32'd0);
    chk({tag, ".flags"}, 32'({fat_a, ev_a, fat_b, ev_b}), 32'd0);
    chk({tag, ".count"}, 32'({cnt_a, cnt_b}), 32'd0);
  endtask

  initial begin
    rst_n = 1'b0; valid_i = 1'b0; err_i = 3'b000; clear_i = 1'b0;
    model_reset();
    #22;
    chk_zero("reset");
    @(negedge clk) rst_n = 1'b1;

    // Break replica 1 with three errors; further errors leave it frozen.
    for (int k = 0; k < 3; k++) cyc(1, 3'b010, 0);
    chk("dir.cnt1", 32'(cnt_a[15:8]), 32'd3);
    chk("dir.brk1", 32'(brk_a), 32'b010);
    chk("dir.ev1", 32'(ev_a), 32'd1);
    cyc(1, 3'b010, 0);
    chk("dir.ev1_off", 32'(ev_a), 32'd0);
    chk("dir.frozen", 32'(cnt_a[15:8]), 32'd3);
    cyc(0, 3'b000, 1);

    for (int k = 0; k < 10; k++) cyc(1, (k % 2 == 0) ? 3'b001 : 3'b000, 0);
    for (int k = 0; k < 4; k++) cyc(1, 3'b000, 0);
    chk("dir.nounderflow", 32'(cnt_a), 32'd0);
    cyc(0, 3'b000, 1);

    cyc(1, 3'b011, 0);
    chk("dir.fatal_maj", 32'(fat_a), 32'd1);
    for (int k = 0; k < 6; k++) cyc(1, 3'b000, 0);
    chk("dir.fatal_sticky", 32'(fat_a), 32'd1);
    cyc(0, 3'b000, 1);

    for (int k = 0; k < 3; k++) cyc(1, 3'b100, 0);
    cyc(1, 3'b110, 0);
    chk("dir.masked", 32'({fat_a, cnt_a[15:8]}), 32'h001);
    cyc(1, 3'b010, 0);
    cyc(1, 3'b010, 0);
    chk("dir.second_break", 32'({brk_a, fat_a, ev_a}), 32'b11011);
    cyc(0, 3'b000, 0);

    cyc(1, 3'b111, 1);
    chk_zero("clear");

    // Asynchronous reset in the middle of counting.
    cyc(1, 3'b001, 0);
    cyc(1, 3'b101, 0);
    #2 rst_n = 1'b0;
    #1;
    chk_zero("async_rst");
    model_reset();
    @(negedge clk) rst_n = 1'b1;

    for (int k = 0; k < 1500; k++) begin
      bit [2:0] e;
      int mode;
      mode = $urandom_range(0, 9);
      if (mode < 5)      e = 3'b000;
      else if (mode < 9) e = 3'(1 << $urandom_range(0, 2));
      else               e = 3'($urandom);
      cyc($urandom_range(0, 3) != 0, e, $urandom_range(0, 39) == 0);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
